// File: rtl/sram_match_arbiter_pkg.sv
// Shared sizes and state/mode types for the SRAM-to-port match arbiter.
package sram_match_arbiter_pkg;
    localparam int NUM_PORTS = 16;
    localparam int NUM_SRAMS = 32;
    localparam int LEN_W     = 11;
    localparam int SRAM_W    = 5;
    localparam int PORT_W    = 4;

    typedef enum logic [1:0] {
        MODE_FIRST     = 2'd0,
        MODE_BEST      = 2'd1,
        MODE_MOST      = 2'd2,
        MODE_FIRST_ALT = 2'd3
    } match_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        FAIL   = 2'd3
    } arb_state_e;
endpackage

// File: rtl/sram_match_arbiter_if.sv
// Request/binding bus between the write-port frontends (master) and the arbiter (slave).
interface sram_match_arbiter_if;
    import sram_match_arbiter_pkg::*;

    logic [SRAM_W-1:0]                 match_threshold;
    logic [1:0]                        match_mode;
    logic [NUM_PORTS-1:0]              match_req;
    logic [NUM_PORTS-1:0][LEN_W-1:0]   match_length;
    logic [NUM_SRAMS-1:0][LEN_W-1:0]   free_space;
    logic [NUM_PORTS-1:0]              release_req;
    logic [NUM_PORTS-1:0]              match_end;
    logic [NUM_PORTS-1:0]              match_fail;
    logic [NUM_PORTS-1:0][SRAM_W-1:0]  match_sram;
    logic [NUM_PORTS-1:0][NUM_SRAMS-1:0] select_sram;
    logic [NUM_SRAMS-1:0]              occupied;

    modport master (
        output match_threshold, match_mode, match_req, match_length, free_space, release_req,
        input  match_end, match_fail, match_sram, select_sram, occupied
    );

    modport slave (
        input  match_threshold, match_mode, match_req, match_length, free_space, release_req,
        output match_end, match_fail, match_sram, select_sram, occupied
    );
endinterface

// File: rtl/sram_match_arbiter_rr_arbiter_16.sv
// Round-robin arbiter over the 16 ports; search starts at the port after the last grant.
module rr_arbiter_16
    import sram_match_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PORT_W-1:0]    grant_idx_o,
    output logic                 valid_o
);
    logic [PORT_W-1:0] ptr_q;
    logic [PORT_W-1:0] ptr_d;
    logic [PORT_W-1:0] probe;

    always_comb begin
        valid_o     = 1'b0;
        grant_idx_o = '0;
        probe       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            probe = ptr_q + PORT_W'(i);
            if (!valid_o && req_i[probe]) begin
                valid_o     = 1'b1;
                grant_idx_o = probe;
            end
        end
    end

    assign grant_o = valid_o ? (NUM_PORTS'(1) << grant_idx_o) : '0;
    assign ptr_d   = grant_idx_o + PORT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/sram_match_arbiter.sv
// Binds free SRAM banks to requesting write ports: round-robin pick, one-bank-per-cycle scan, hold until release.
module sram_match_arbiter
    import sram_match_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sram_match_arbiter_if.slave  bus
);
    arb_state_e                          state_q;
    logic [PORT_W-1:0]                   port_q;
    logic [LEN_W-1:0]                    len_q;
    match_mode_e                         mode_q;
    logic [SRAM_W-1:0]                   cnt_q;
    logic [SRAM_W-1:0]                   start_q;
    logic [SRAM_W-1:0]                   cand_q, cand_d;
    logic                                cand_valid_q, cand_valid_d;
    logic [LEN_W-1:0]                    cand_free_q, cand_free_d;
    logic [NUM_SRAMS-1:0]                occupied_q;
    logic [NUM_PORTS-1:0][NUM_SRAMS-1:0] select_q;
    logic [NUM_PORTS-1:0][SRAM_W-1:0]    msram_q;
    logic [NUM_PORTS-1:0]                end_q;
    logic [NUM_PORTS-1:0]                fail_q;

    logic [NUM_PORTS-1:0] bound;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [PORT_W-1:0]    arb_idx;
    logic                 arb_valid;
    logic [LEN_W-1:0]     grant_len;
    logic [SRAM_W-1:0]    scan_idx;
    logic [LEN_W-1:0]     idx_free;
    logic                 eligible;
    logic                 take;
    logic                 first_mode;
    logic [SRAM_W:0]      thr_eff;
    logic                 reached;

    always_comb begin
        bound     = '0;
        grant_len = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bound[p] = |select_q[p];
            if (arb_grant[p]) grant_len = grant_len | bus.match_length[p];
        end
    end

    assign arb_req = bus.match_req & ~bound;

    rr_arbiter_16 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (arb_req),
        .advance_i   (state_q == IDLE),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    // Scan evaluates against registered occupancy, so a bank released this cycle is seen next cycle.
    assign scan_idx   = start_q + cnt_q;
    assign idx_free   = bus.free_space[scan_idx];
    assign eligible   = !occupied_q[scan_idx] && (idx_free >= len_q);
    assign first_mode = (mode_q == MODE_FIRST) || (mode_q == MODE_FIRST_ALT);
    assign thr_eff    = (bus.match_threshold == '0) ? (SRAM_W+1)'(NUM_SRAMS)
                                                    : {1'b0, bus.match_threshold};
    assign reached    = ({1'b0, cnt_q} + (SRAM_W+1)'(1)) >= thr_eff;

    always_comb begin
        case (mode_q)
            MODE_BEST: take = eligible && (!cand_valid_q || idx_free < cand_free_q);
            MODE_MOST: take = eligible && (!cand_valid_q || idx_free > cand_free_q);
            default:   take = eligible;
        endcase
        cand_d       = take ? scan_idx : cand_q;
        cand_free_d  = take ? idx_free : cand_free_q;
        cand_valid_d = cand_valid_q || take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= '0;
            len_q        <= '0;
            mode_q       <= MODE_FIRST;
            cnt_q        <= '0;
            start_q      <= '0;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            cand_free_q  <= '0;
            occupied_q   <= '0;
            select_q     <= '0;
            msram_q      <= '0;
            end_q        <= '0;
            fail_q       <= '0;
        end else begin
            end_q  <= '0;
            fail_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.release_req[p] && bound[p]) begin
                    occupied_q[msram_q[p]] <= 1'b0;
                    select_q[p]            <= '0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        port_q       <= arb_idx;
                        len_q        <= grant_len;
                        mode_q       <= match_mode_e'(bus.match_mode);
                        cnt_q        <= '0;
                        cand_valid_q <= 1'b0;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    cand_q       <= cand_d;
                    cand_free_q  <= cand_free_d;
                    cand_valid_q <= cand_valid_d;
                    cnt_q        <= cnt_q + SRAM_W'(1);
                    if (first_mode && take) begin
                        state_q <= COMMIT;
                    end else if (cand_valid_d && reached) begin
                        state_q <= COMMIT;
                    end else if (cnt_q == SRAM_W'(NUM_SRAMS - 1)) begin
                        state_q <= FAIL;
                    end
                end
                COMMIT: begin
                    occupied_q[cand_q] <= 1'b1;
                    select_q[port_q]   <= NUM_SRAMS'(1) << cand_q;
                    msram_q[port_q]    <= cand_q;
                    end_q[port_q]      <= 1'b1;
                    start_q            <= cand_q + SRAM_W'(1);
                    state_q            <= IDLE;
                end
                default: begin
                    end_q[port_q]  <= 1'b1;
                    fail_q[port_q] <= 1'b1;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign bus.match_end   = end_q;
    assign bus.match_fail  = fail_q;
    assign bus.match_sram  = msram_q;
    assign bus.select_sram = select_q;
    assign bus.occupied    = occupied_q;
endmodule

// File: tb/tb_sram_match_arbiter.sv
// Directed bench for sram_match_arbiter: latency, arbitration order, match modes, fail, release and reset.
module tb_sram_match_arbiter;
    import sram_match_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    sram_match_arbiter_if bus ();

    sram_match_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_PORTS-1:0] req, input logic [NUM_PORTS-1:0] rel);
        bus.match_req   = req;
        bus.release_req = rel;
    endtask

    task automatic setFree(input logic [LEN_W-1:0] val);
        for (int s = 0; s < NUM_SRAMS; s++) bus.free_space[s] = val;
    endtask

    task automatic setLen(input logic [LEN_W-1:0] val);
        for (int p = 0; p < NUM_PORTS; p++) bus.match_length[p] = val;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Counts edges from the current cycle until match_end[port] is seen, bounded by maxCycles.
    task automatic waitEnd(input int port, input int maxCycles, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus.match_end[port] && cycles < maxCycles);
        if (!bus.match_end[port]) checkOutput("wait_end_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.match_threshold = 5'd1;
        bus.match_mode      = 2'd0;
        applyStimulus('0, '0);
        setFree(11'd2047);
        setLen(11'd10);
        tick();
        tick();

        checkOutput("reset_occupied", 64'(bus.occupied), 64'd0);
        checkOutput("reset_end", 64'(bus.match_end), 64'd0);
        checkOutput("reset_fail", 64'(bus.match_fail), 64'd0);
        checkOutput("reset_select3", 64'(bus.select_sram[3]), 64'd0);
        checkOutput("reset_sram3", 64'(bus.match_sram[3]), 64'd0);

        // Basic first-fit, first SRAM eligible.
        rst = 1'b0;
        applyStimulus(16'h0008, '0);
        waitEnd(3, 40, cyc);
        checkOutput("t1_latency", 64'(cyc), 64'd3);
        checkOutput("t1_end", 64'(bus.match_end), 64'h0008);
        checkOutput("t1_sram3", 64'(bus.match_sram[3]), 64'd0);
        checkOutput("t1_select3", 64'(bus.select_sram[3]), 64'h1);
        checkOutput("t1_occupied", 64'(bus.occupied), 64'h1);
        applyStimulus('0, '0);

        // Two simultaneous requests: round-robin order, no overlapping bindings.
        doReset();
        applyStimulus(16'h0021, '0);
        waitEnd(0, 40, cyc);
        checkOutput("t2_p0_latency", 64'(cyc), 64'd3);
        checkOutput("t2_p0_sram", 64'(bus.match_sram[0]), 64'd0);
        waitEnd(5, 40, cyc);
        checkOutput("t2_p5_latency", 64'(cyc), 64'd3);
        checkOutput("t2_p5_sram", 64'(bus.match_sram[5]), 64'd1);
        checkOutput("t2_overlap", 64'(bus.select_sram[0] & bus.select_sram[5]), 64'd0);
        checkOutput("t2_occupied", 64'(bus.occupied), 64'h3);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t2_bound_ignored", 64'(bus.match_end), 64'd0);
        applyStimulus('0, '0);

        // Release on one port in the same cycle as another port's commit.
        doReset();
        applyStimulus(16'h0008, '0);
        waitEnd(3, 40, cyc);
        checkOutput("t5_p3_sram", 64'(bus.match_sram[3]), 64'd0);
        applyStimulus(16'h0080, '0);
        tick();
        tick();
        applyStimulus(16'h0080, 16'h0008);
        tick();
        applyStimulus('0, '0);
        checkOutput("t5_end", 64'(bus.match_end), 64'h0080);
        checkOutput("t5_occupied", 64'(bus.occupied), 64'h2);
        checkOutput("t5_select3", 64'(bus.select_sram[3]), 64'd0);
        checkOutput("t5_select7", 64'(bus.select_sram[7]), 64'h2);
        checkOutput("t5_sram7", 64'(bus.match_sram[7]), 64'd1);

        // Best-fit and most-free with a full scan (threshold 0 means 32).
        doReset();
        setFree(11'd10);
        bus.free_space[4]   = 11'd100;
        bus.free_space[9]   = 11'd50;
        setLen(11'd40);
        bus.match_mode      = 2'd1;
        bus.match_threshold = 5'd0;
        applyStimulus(16'h0004, '0);
        waitEnd(2, 40, cyc);
        checkOutput("t3_best_latency", 64'(cyc), 64'd34);
        checkOutput("t3_best_sram", 64'(bus.match_sram[2]), 64'd9);
        checkOutput("t3_best_fail", 64'(bus.match_fail), 64'd0);
        checkOutput("t3_best_occupied", 64'(bus.occupied), 64'h200);
        applyStimulus('0, 16'h0004);
        tick();
        applyStimulus('0, '0);
        checkOutput("t3_release_occupied", 64'(bus.occupied), 64'd0);
        checkOutput("t3_release_select", 64'(bus.select_sram[2]), 64'd0);

        bus.match_mode = 2'd2;
        applyStimulus(16'h0004, '0);
        waitEnd(2, 40, cyc);
        checkOutput("t3_most_latency", 64'(cyc), 64'd34);
        checkOutput("t3_most_sram", 64'(bus.match_sram[2]), 64'd4);
        applyStimulus('0, 16'h0004);
        tick();
        applyStimulus('0, '0);

        // Threshold 1 in most-free mode stops at the first eligible bank after start (5).
        bus.match_threshold = 5'd1;
        applyStimulus(16'h0004, '0);
        waitEnd(2, 40, cyc);
        checkOutput("t3_thr1_latency", 64'(cyc), 64'd7);
        checkOutput("t3_thr1_sram", 64'(bus.match_sram[2]), 64'd9);
        applyStimulus('0, '0);

        // No eligible bank: fail pulse, bindings untouched.
        setFree(11'd10);
        bus.match_mode = 2'd0;
        applyStimulus(16'h0040, '0);
        waitEnd(6, 40, cyc);
        applyStimulus('0, '0);
        checkOutput("t4_latency", 64'(cyc), 64'd34);
        checkOutput("t4_end", 64'(bus.match_end), 64'h0040);
        checkOutput("t4_fail", 64'(bus.match_fail), 64'h0040);
        checkOutput("t4_occupied", 64'(bus.occupied), 64'h200);
        checkOutput("t4_select6", 64'(bus.select_sram[6]), 64'd0);
        tick();
        checkOutput("t4_end_pulse", 64'(bus.match_end), 64'd0);
        checkOutput("t4_fail_pulse", 64'(bus.match_fail), 64'd0);

        // Reset mid-scan aborts silently; held request is re-served afterwards.
        setFree(11'd2047);
        bus.match_mode      = 2'd1;
        bus.match_threshold = 5'd0;
        applyStimulus(16'h0010, '0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t6_no_end_scan", 64'(bus.match_end), 64'd0);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_occupied", 64'(bus.occupied), 64'd0);
        checkOutput("t6_rst_select2", 64'(bus.select_sram[2]), 64'd0);
        checkOutput("t6_rst_end", 64'(bus.match_end), 64'd0);
        checkOutput("t6_rst_sram2", 64'(bus.match_sram[2]), 64'd0);
        rst = 1'b0;
        waitEnd(4, 40, cyc);
        checkOutput("t6_rescan_latency", 64'(cyc), 64'd34);
        checkOutput("t6_rescan_sram", 64'(bus.match_sram[4]), 64'd0);
        checkOutput("t6_rescan_occupied", 64'(bus.occupied), 64'h1);
        applyStimulus('0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
